// File: rtl/fod_mmd_div.sv
// fod_mmd_div: multi-modulus clock divider with per-period ratio, retimer and DTC word alignment
//   clk_i          PLL clock, rising edge only
//   nrst_i         synchronous active-low reset
//   en_i           enable; low freezes all state
//   mmd_dcw_i      next division ratio (4..63), clamped to MIN_DIV
//   rt_dcw_i       retimer select for the next period
//   dtc_dcw_i      DTC code for the next period
//   clr_err_i      clears the sticky range error
//   div_pulse_o    terminal-count pulse / word-request strobe
//   div_clk_o      divided clock, ceil(N/2) high cycles per period
//   rt_sel_o       retimer select for the current period
//   dtc_code_o     DTC code for the current period
//   range_err_o    sticky flag: a sampled ratio was below MIN_DIV
//   period_cnt_o   completed-period counter, wrapping
module fod_mmd_div #(
  parameter int RST_DIV = 4,
  parameter int MIN_DIV = 4
) (
  input  logic        clk_i,
  input  logic        nrst_i,
  input  logic        en_i,
  input  logic [5:0]  mmd_dcw_i,
  input  logic        rt_dcw_i,
  input  logic [9:0]  dtc_dcw_i,
  input  logic        clr_err_i,
  output logic        div_pulse_o,
  output logic        div_clk_o,
  output logic        rt_sel_o,
  output logic [9:0]  dtc_code_o,
  output logic        range_err_o,
  output logic [15:0] period_cnt_o
);
  localparam logic [5:0] RST_N = 6'(RST_DIV);
  localparam logic [5:0] MIN_N = 6'(MIN_DIV);
  logic [5:0]  cnt_q, cnt_d, n_q, n_d, n_next;
  logic        zero_q, zero_d, clk_q, clk_d, rt_q, rt_d, err_q, err_d, sample;
  logic [9:0]  dtc_q, dtc_d;
  logic [15:0] pc_q, pc_d;
  always_comb begin
    sample = en_i && zero_q;
    n_next = mmd_dcw_i < MIN_N ? MIN_N : mmd_dcw_i;
    cnt_d  = !en_i ? cnt_q : sample ? n_next - 6'd1 : cnt_q - 6'd1;
    n_d    = sample ? n_next : n_q;
    zero_d = cnt_d == 6'd0;
    // next-state compare so the divided clock is a plain flop output
    clk_d  = en_i ? cnt_d >= (n_d >> 1) : clk_q;
    rt_d   = sample ? rt_dcw_i : rt_q;
    dtc_d  = sample ? dtc_dcw_i : dtc_q;
    // a new error wins over a simultaneous clear
    err_d  = (sample && mmd_dcw_i < MIN_N) || (err_q && !clr_err_i);
    pc_d   = sample ? pc_q + 16'd1 : pc_q;
  end
  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      cnt_q  <= RST_N - 6'd1;
      n_q    <= RST_N;
      zero_q <= 1'b0;
      clk_q  <= 1'b0;
      rt_q   <= 1'b0;
      dtc_q  <= '0;
      err_q  <= 1'b0;
      pc_q   <= '0;
    end else begin
      cnt_q  <= cnt_d;
      n_q    <= n_d;
      zero_q <= zero_d;
      clk_q  <= clk_d;
      rt_q   <= rt_d;
      dtc_q  <= dtc_d;
      err_q  <= err_d;
      pc_q   <= pc_d;
    end
  end
  // terminal-count flop gated by enable so a frozen divider never requests a word
  assign div_pulse_o  = zero_q && en_i;
  assign div_clk_o    = clk_q;
  assign rt_sel_o     = rt_q;
  assign dtc_code_o   = dtc_q;
  assign range_err_o  = err_q;
  assign period_cnt_o = pc_q;
endmodule

// File: tb/tb_fod_mmd_div.sv
// tb_fod_mmd_div: scoreboard bench for fod_mmd_div with directed per-period expectations
module tb_fod_mmd_div;
  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        en = 1'b1;
  logic [5:0]  mmd_dcw = 6'd4;
  logic        rt_dcw = 1'b0;
  logic [9:0]  dtc_dcw = '0;
  logic        clr_err = 1'b0;
  logic        div_pulse, div_clk, rt_sel, range_err;
  logic [9:0]  dtc_code;
  logic [15:0] period_cnt;
  int n_tests = 0;
  int n_fail = 0;
  typedef struct {
    int         len;
    int         hi;
    logic       rt;
    logic [9:0] dtc;
    logic       err;
  } exp_t;
  exp_t exp_q[$];
  int mon_len = 0;
  int mon_hi = 0;
  fod_mmd_div dut (
    .clk_i(clk), .nrst_i(nrst), .en_i(en), .mmd_dcw_i(mmd_dcw), .rt_dcw_i(rt_dcw),
    .dtc_dcw_i(dtc_dcw), .clr_err_i(clr_err), .div_pulse_o(div_pulse), .div_clk_o(div_clk),
    .rt_sel_o(rt_sel), .dtc_code_o(dtc_code), .range_err_o(range_err), .period_cnt_o(period_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // monitor: measures each divided period in enabled cycles and checks it against the scoreboard
  always @(negedge clk) begin
    if (!nrst) begin
      mon_len = 0;
      mon_hi = 0;
    end else if (en) begin
      mon_len++;
      if (div_clk) mon_hi++;
      if (div_pulse) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_pulse: got pulse expected none");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("period_len", mon_len, e.len);
          chk("high_cycles", mon_hi, e.hi);
          chk("rt_sel", {31'd0, rt_sel}, {31'd0, e.rt});
          chk("dtc_code", {22'd0, dtc_code}, {22'd0, e.dtc});
          chk("range_err", {31'd0, range_err}, {31'd0, e.err});
        end
        mon_len = 0;
        mon_hi = 0;
      end
    end
  end
  task automatic wait_pulse();
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = div_pulse;
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL pulse_timeout: got no pulse expected one within 100 cycles");
    end
  endtask
  // present a word, queue the expectation for the period it sets up, let the DUT sample it
  task automatic step(input logic [5:0] mmd, input logic rt, input logic [9:0] dtc,
                      input int len, input int hi, input logic err, input logic clr);
    exp_t e;
    mmd_dcw = mmd;
    rt_dcw = rt;
    dtc_dcw = dtc;
    e = '{len: len, hi: hi, rt: rt, dtc: dtc, err: err};
    exp_q.push_back(e);
    wait_pulse();
    clr_err = clr;
    @(posedge clk);
    #1 clr_err = 1'b0;
  endtask
  task automatic do_reset();
    exp_t e;
    exp_q.delete();
    e = '{len: 4, hi: 1, rt: 1'b0, dtc: 10'd0, err: 1'b0};
    exp_q.push_back(e);
    @(posedge clk);
    #1 nrst = 1'b0;
    @(posedge clk);
    #1 nrst = 1'b1;
    @(negedge clk);
    chk("rst_pulse", {31'd0, div_pulse}, 32'd0);
    chk("rst_div_clk", {31'd0, div_clk}, 32'd0);
    chk("rst_rt_sel", {31'd0, rt_sel}, 32'd0);
    chk("rst_dtc", {22'd0, dtc_code}, 32'd0);
    chk("rst_err", {31'd0, range_err}, 32'd0);
    chk("rst_pcnt", {16'd0, period_cnt}, 32'd0);
  endtask
  initial begin
    do_reset();
    step(6'd4, 1'b0, 10'h000, 4, 2, 1'b0, 1'b0);
    step(6'd4, 1'b0, 10'h000, 4, 2, 1'b0, 1'b0);
    step(6'd4, 1'b0, 10'h000, 4, 2, 1'b0, 1'b0);
    @(negedge clk);
    chk("pcnt_after_3", {16'd0, period_cnt}, 32'd3);
    step(6'd5, 1'b1, 10'h155, 5, 3, 1'b0, 1'b0);
    @(negedge clk);
    chk("rt_follows", {31'd0, rt_sel}, 32'd1);
    chk("dtc_follows", {22'd0, dtc_code}, 32'h155);
    step(6'd6, 1'b0, 10'h2AA, 6, 3, 1'b0, 1'b0);
    step(6'd5, 1'b1, 10'h001, 5, 3, 1'b0, 1'b0);
    step(6'd6, 1'b0, 10'h3FF, 6, 3, 1'b0, 1'b0);
    @(negedge clk);
    chk("dtc_follows2", {22'd0, dtc_code}, 32'h3FF);
    step(6'd2, 1'b1, 10'h0F0, 4, 2, 1'b1, 1'b0);
    @(negedge clk);
    chk("err_set", {31'd0, range_err}, 32'd1);
    step(6'd5, 1'b0, 10'h00F, 5, 3, 1'b0, 1'b1);
    @(negedge clk);
    chk("err_cleared", {31'd0, range_err}, 32'd0);
    step(6'd3, 1'b1, 10'h123, 4, 2, 1'b1, 1'b1);
    @(negedge clk);
    chk("err_set_wins", {31'd0, range_err}, 32'd1);
    step(6'd63, 1'b1, 10'h2AB, 63, 32, 1'b0, 1'b1);
    mmd_dcw = 6'd0;
    rt_dcw = 1'b0;
    dtc_dcw = 10'h000;
    repeat (10) @(posedge clk);
    #1 en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("frz_pulse", {31'd0, div_pulse}, 32'd0);
      chk("frz_div_clk", {31'd0, div_clk}, 32'd1);
      chk("frz_rt", {31'd0, rt_sel}, 32'd1);
      chk("frz_dtc", {22'd0, dtc_code}, 32'h2AB);
      chk("frz_pcnt", {16'd0, period_cnt}, 32'd11);
      @(posedge clk);
    end
    #1 en = 1'b1;
    step(6'd4, 1'b0, 10'h050, 4, 2, 1'b0, 1'b0);
    force dut.pc_q = 16'hFFFF;
    #1 release dut.pc_q;
    @(negedge clk);
    chk("pcnt_preload", {16'd0, period_cnt}, 32'hFFFF);
    step(6'd4, 1'b1, 10'h060, 4, 2, 1'b0, 1'b0);
    @(negedge clk);
    chk("pcnt_wrap", {16'd0, period_cnt}, 32'h0000);
    step(6'd1, 1'b0, 10'h111, 4, 2, 1'b1, 1'b0);
    step(6'd40, 1'b1, 10'h3C3, 40, 20, 1'b1, 1'b0);
    repeat (18) @(posedge clk);
    do_reset();
    step(6'd4, 1'b0, 10'h000, 4, 2, 1'b0, 1'b0);
    wait_pulse();
    @(posedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
